// File: rtl/mem_port_arbiter.sv
// Purpose: shares one bram_sdp between instruction fetch and load/store, round-robin on contention.
// Latency: grant in request cycle N, BRAM strobe in N+1, rvalid/rdata in N+2, next grant from N+3.
// Backpressure: requesters hold req until their combinational gnt; one transaction per 3-cycle slot.
//
// Ports: clock/reset (async, active-high); fetch port if_*; data port d_*; BRAM side mem_*.
// Optional build macro ARB_LOADER_EN adds a write-only, highest-priority loader port ld_*.
module mem_port_arbiter #(
    parameter int MEM_DEPTH      = 4096,
    parameter int MEM_ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      if_req,
    input  logic [31:0]               if_addr,
    output logic                      if_gnt,
    output logic                      if_rvalid,
    output logic [31:0]               if_rdata,
    input  logic                      d_req,
    input  logic                      d_we,
    input  logic [31:0]               d_addr,
    input  logic [31:0]               d_wdata,
    input  logic [3:0]                d_wmask,
    output logic                      d_gnt,
    output logic                      d_rvalid,
    output logic [31:0]               d_rdata,
    output logic                      d_err,
`ifdef ARB_LOADER_EN
    input  logic                      ld_req,
    input  logic [31:0]               ld_addr,
    input  logic [31:0]               ld_wdata,
    output logic                      ld_gnt,
    output logic                      ld_done,
`endif
    output logic                      mem_read_enable,
    output logic                      mem_write_enable,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_read,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_write,
    output logic [31:0]               mem_write_data,
    output logic [3:0]                mem_mask_write,
    input  logic [31:0]               mem_data_out
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    localparam logic [1:0] SRC_IF = 2'd0;
    localparam logic [1:0] SRC_D  = 2'd1;
    localparam logic [1:0] SRC_LD = 2'd2;

    localparam logic LG_FETCH = 1'b0;
    localparam logic LG_DATA  = 1'b1;

    logic [1:0]  state;
    logic        last_grant;
    logic [1:0]  src_q;
    logic        we_q;
    logic        oor_q;
    logic        if_rd_q;
    logic        d_rd_q;

    // Loader request path; tied off when the loader is not built.
    logic        ld_win;
    logic        ld_gnt_i;
    logic [31:0] ld_addr_i;
    logic [31:0] ld_wdata_i;

`ifdef ARB_LOADER_EN
    assign ld_win     = ld_req;
    assign ld_addr_i  = ld_addr;
    assign ld_wdata_i = ld_wdata;
    assign ld_gnt     = ld_gnt_i;
`else
    assign ld_win     = 1'b0;
    assign ld_addr_i  = '0;
    assign ld_wdata_i = '0;
`endif

    logic        idle;
    logic        any_gnt;
    logic [31:0] sel_addr;
    logic        sel_we;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_wmask;
    logic        sel_oor;
    logic [MEM_ADDR_WIDTH-1:0] sel_word;

    assign idle     = (state == IDLE);
    assign ld_gnt_i = idle && ld_win;

    // Round-robin: on contention the requester that did not win last time goes first.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (idle && !ld_win) begin
            if (if_req && d_req) begin
                if (last_grant == LG_DATA) if_gnt = 1'b1;
                else                       d_gnt  = 1'b1;
            end else begin
                if_gnt = if_req;
                d_gnt  = d_req;
            end
        end
    end

    assign any_gnt = if_gnt | d_gnt | ld_gnt_i;

    always_comb begin
        sel_addr  = if_addr;
        sel_we    = 1'b0;
        sel_wdata = '0;
        sel_wmask = '0;
        if (ld_gnt_i) begin
            sel_addr  = ld_addr_i;
            sel_we    = 1'b1;
            sel_wdata = ld_wdata_i;
            sel_wmask = 4'b1111;
        end else if (d_gnt) begin
            sel_addr  = d_addr;
            sel_we    = d_we;
            sel_wdata = d_wdata;
            sel_wmask = d_wmask;
        end
    end

    assign sel_word = sel_addr[MEM_ADDR_WIDTH+1:2];
    assign sel_oor  = |(sel_addr >> (MEM_ADDR_WIDTH + 2));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            last_grant       <= LG_DATA;
            src_q            <= SRC_IF;
            we_q             <= 1'b0;
            oor_q            <= 1'b0;
            if_rd_q          <= 1'b0;
            d_rd_q           <= 1'b0;
            if_rvalid        <= 1'b0;
            d_rvalid         <= 1'b0;
            d_err            <= 1'b0;
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_addr_read    <= '0;
            mem_addr_write   <= '0;
            mem_write_data   <= '0;
            mem_mask_write   <= '0;
`ifdef ARB_LOADER_EN
            ld_done          <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_gnt) begin
                        state            <= ISSUE;
                        src_q            <= ld_gnt_i ? SRC_LD : (d_gnt ? SRC_D : SRC_IF);
                        we_q             <= sel_we;
                        oor_q            <= sel_oor;
                        mem_read_enable  <= !sel_we && !sel_oor;
                        mem_write_enable <= sel_we && !sel_oor;
                        mem_addr_read    <= sel_word;
                        mem_addr_write   <= sel_word;
                        mem_write_data   <= sel_wdata;
                        mem_mask_write   <= sel_wmask;
                        if (if_gnt)     last_grant <= LG_FETCH;
                        else if (d_gnt) last_grant <= LG_DATA;
                    end
                end
                ISSUE: begin
                    state            <= RESP;
                    mem_read_enable  <= 1'b0;
                    mem_write_enable <= 1'b0;
                    if_rvalid        <= (src_q == SRC_IF);
                    d_rvalid         <= (src_q == SRC_D);
                    d_err            <= (src_q == SRC_D) && oor_q;
                    if_rd_q          <= (src_q == SRC_IF) && !oor_q;
                    d_rd_q           <= (src_q == SRC_D) && !we_q && !oor_q;
`ifdef ARB_LOADER_EN
                    ld_done          <= (src_q == SRC_LD);
`endif
                end
                RESP: begin
                    state     <= IDLE;
                    if_rvalid <= 1'b0;
                    d_rvalid  <= 1'b0;
                    d_err     <= 1'b0;
                    if_rd_q   <= 1'b0;
                    d_rd_q    <= 1'b0;
`ifdef ARB_LOADER_EN
                    ld_done   <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The BRAM output register already holds the word during RESP; a registered
    // qualifier selects it so read data lands in the same cycle as rvalid.
    assign if_rdata = if_rd_q ? mem_data_out : '0;
    assign d_rdata  = d_rd_q  ? mem_data_out : '0;

endmodule
